// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and word-write output of the instruction-memory loader.
interface imem_loader_if #(
  parameter int ADDR_W = 64
);

  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Lane counter plus byte-to-word assembly; emits a registered one-cycle
// pulse carrying each completed little-endian word.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    byte_fire,
  input  logic [7:0]              byte_data,
  output logic                    last_lane,
  output logic                    word_valid,
  output logic [WORD_BYTES*8-1:0] word_data
);

  logic [1:0]  lane;
  logic [23:0] partial;

  assign last_lane = (lane == 2'd3);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane       <= '0;
      partial    <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane    <= '0;
        partial <= '0;
      end else if (byte_fire) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    partial[7:0]   <= byte_data;
          2'd1:    partial[15:8]  <= byte_data;
          2'd2:    partial[23:16] <= byte_data;
          default: begin
            word_valid <= 1'b1;
            word_data  <= {byte_data, partial};
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core
// in reset until done. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 80,
  parameter int ADDR_W      = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          done,
  output logic          err
);

  localparam int MAX_WORDS = DEPTH_BYTES / WORD_BYTES;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t ST_FINAL = ST_CHECK;
  logic [7:0] csum;
`else
  localparam state_t ST_FINAL = ST_DONE;
`endif

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [LEN_W-1:0] len_full;
  logic             fire, start_ok, data_fire, last_lane, word_valid;
  logic [31:0]      word_data;

  assign fire      = bus.rx_valid && bus.rx_ready;
  assign start_ok  = start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign data_fire = fire && (state == ST_DATA);
  assign len_full  = {bus.rx_data, len_q[7:0]};

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .byte_fire (data_fire),
    .byte_data (bus.rx_data),
    .last_lane (last_lane),
    .word_valid(word_valid),
    .word_data (word_data)
  );

  // NOTE: next state gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) state_nxt = ST_LEN0;
      ST_LEN0: if (fire) state_nxt = ST_LEN1;
      ST_LEN1: if (fire) begin
        if ({16'd0, len_full} > 32'(MAX_WORDS)) state_nxt = ST_ERR;
        else if (len_full == '0)                state_nxt = ST_FINAL;
        else                                    state_nxt = ST_DATA;
      end
      // word_idx still names the word being filled: it advances on the write pulse.
      ST_DATA: if (fire && last_lane && (word_idx == len_q - LEN_W'(1))) state_nxt = ST_FINAL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: if (fire) state_nxt = (bus.rx_data == csum) ? ST_DONE : ST_ERR;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      word_idx <= '0;
    end else begin
      state <= state_nxt;
      if (fire && state == ST_LEN0) len_q[7:0]  <= bus.rx_data;
      if (fire && state == ST_LEN1) len_q[15:8] <= bus.rx_data;
      if (start_ok)        word_idx <= '0;
      else if (word_valid) word_idx <= word_idx + LEN_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         csum <= '0;
    else if (start_ok)  csum <= '0;
    else if (data_fire) csum <= csum ^ bus.rx_data;
  end
`endif

  assign bus.rx_ready  = state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CHECK};
  assign bus.mem_we    = word_valid;
  assign bus.mem_wdata = word_data;
  assign bus.mem_addr  = ADDR_W'({word_idx, 2'b00});
  assign done          = (state == ST_DONE);
  assign err           = (state == ST_ERR);
  assign core_hold     = (state != ST_DONE);

endmodule
